// File: rtl/smoldvi_symbol_shifter.sv
// smoldvi_symbol_shifter
//
// 10:2 TMDS symbol shifter for one DVI data lane. The whole block runs in the
// half-rate bit-clock domain (clk_x5 = 5x pixel clock). Symbols arrive over a
// valid/ready handshake into a 2-entry FIFO. Each clk_x5 cycle the block
// presents one rise/fall bit pair to the lane's DDR output cell. Bit 0 of a
// symbol is sent first.
//
// Ports
//   clk_x5          in   1   half-rate bit clock
//   rst_x5          in   1   asynchronous reset, active-high
//   in_valid        in   1   in_data holds a valid symbol
//   in_ready        out  1   FIFO can accept a symbol this cycle
//   in_data         in   10  TMDS symbol, bit 0 transmitted first
//   q_rise          out  1   bit for the rising-edge half of this cycle
//   q_fall          out  1   bit for the falling-edge half of this cycle
//   sym_start       out  1   high while bits [1:0] of a symbol are on q_*
//   underflow       out  1   one-cycle pulse, IDLE_SYMBOL loaded from empty FIFO
//   underflow_cnt   out  8   saturating underflow count   (optional, see below)
//   underflow_seen  out  1   sticky underflow flag         (optional, see below)
//
// Configuration
//   SMOLDVI_SHIFTER_UNDERFLOW_CNT_EN  when defined, adds underflow_cnt and
//   underflow_seen plus their flops. The default build has neither.

module smoldvi_symbol_shifter #(
    parameter logic [9:0] IDLE_SYMBOL = 10'b1101010100
) (
    input  logic       clk_x5,
    input  logic       rst_x5,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [9:0] in_data,
    output logic       q_rise,
    output logic       q_fall,
    output logic       sym_start,
    output logic       underflow
`ifdef SMOLDVI_SHIFTER_UNDERFLOW_CNT_EN
    ,
    output logic [7:0] underflow_cnt,
    output logic       underflow_seen
`endif
);

    // The phase counter steps 0..4. Phase 4 is the cycle whose closing edge
    // reloads the shift register.
    localparam logic [2:0] PHASE_FIRST = 3'd0;
    localparam logic [2:0] PHASE_LOAD  = 3'd4;
    localparam logic [1:0] FIFO_DEPTH  = 2'd2;

    logic [2:0] phase;
    logic [9:0] shreg;
    logic       sym_start_q;
    logic       underflow_q;

    logic [9:0] fifo_mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] fifo_count;
    logic [1:0] fifo_count_next;
    logic       in_ready_q;

    logic       load_edge;
    logic       fifo_empty;
    logic       push;
    logic       pop;

    // in_ready comes from a flop, so push does not depend combinationally
    // on in_ready logic or phase.
    assign load_edge  = (phase == PHASE_LOAD);
    assign fifo_empty = (fifo_count == 2'd0);
    assign push       = in_valid && in_ready_q;
    assign pop        = load_edge && !fifo_empty;

    // A push and a pop on the same edge leave the occupancy unchanged.
    always_comb begin
        fifo_count_next = fifo_count;
        case ({push, pop})
            2'b10:   fifo_count_next = fifo_count + 2'd1;
            2'b01:   fifo_count_next = fifo_count - 2'd1;
            default: fifo_count_next = fifo_count;
        endcase
    end

    // FIFO storage has no reset. Entries are read only while counted as
    // occupied, and they are written only on an accepted push. This keeps
    // an X on in_data with in_valid low away from the datapath.
    always_ff @(posedge clk_x5) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk_x5 or posedge rst_x5) begin
        if (rst_x5) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
            in_ready_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count_next;
            in_ready_q <= (fifo_count_next != FIFO_DEPTH);
        end
    end

    // Phase counter. sym_start is registered as "the next phase is 0".
    always_ff @(posedge clk_x5 or posedge rst_x5) begin
        if (rst_x5) begin
            phase       <= PHASE_FIRST;
            sym_start_q <= 1'b1;
        end else begin
            if (load_edge) begin
                phase <= PHASE_FIRST;
            end else begin
                phase <= phase + 3'd1;
            end
            sym_start_q <= load_edge;
        end
    end

    // Shift register. It shifts two bits per cycle and reloads on the edge
    // that leaves phase 4. The load uses the FIFO head as it was before this
    // edge. A symbol pushed on the same edge therefore waits a full frame.
    always_ff @(posedge clk_x5 or posedge rst_x5) begin
        if (rst_x5) begin
            shreg <= IDLE_SYMBOL;
        end else if (load_edge) begin
            if (fifo_empty) begin
                shreg <= IDLE_SYMBOL;
            end else begin
                shreg <= fifo_mem[rd_ptr];
            end
        end else begin
            shreg <= {2'b00, shreg[9:2]};
        end
    end

    // The underflow pulse lines up with sym_start of the idle frame.
    always_ff @(posedge clk_x5 or posedge rst_x5) begin
        if (rst_x5) begin
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= load_edge && fifo_empty;
        end
    end

`ifdef SMOLDVI_SHIFTER_UNDERFLOW_CNT_EN
    logic [7:0] underflow_cnt_q;
    logic       underflow_seen_q;

    // Statistics update on the same edge that raises the underflow pulse.
    // The counter saturates and stops at 8'hFF.
    always_ff @(posedge clk_x5 or posedge rst_x5) begin
        if (rst_x5) begin
            underflow_cnt_q  <= 8'h00;
            underflow_seen_q <= 1'b0;
        end else if (load_edge && fifo_empty) begin
            if (underflow_cnt_q != 8'hFF) begin
                underflow_cnt_q <= underflow_cnt_q + 8'h01;
            end
            underflow_seen_q <= 1'b1;
        end
    end

    assign underflow_cnt  = underflow_cnt_q;
    assign underflow_seen = underflow_seen_q;
`endif

    assign in_ready  = in_ready_q;
    assign q_rise    = shreg[0];
    assign q_fall    = shreg[1];
    assign sym_start = sym_start_q;
    assign underflow = underflow_q;

endmodule
